// File: rtl/control_sequencer.sv
// Multi-cycle control unit: holds IR, walks fetch/execute T-states, drives datapath strobes.
// Moore outputs from the state register; only PCin/ZLowOut in branch T6 depend on con_ff.
module control_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0,
  parameter logic [4:0]  ADD_OP   = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] bus_in,
  input  logic        con_ff,
  input  logic        stop,
  output logic [15:0] Rin_vec,
  output logic [15:0] Rout_vec,
  output logic [31:0] C_sext,
  output logic [4:0]  alu_op,
  output logic        PCout,
  output logic        PCin,
  output logic        incPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIin,
  output logic        LOin,
  output logic        Cout,
  output logic        CONin,
  output logic        run,
  output logic [31:0] ir_q
);

  typedef enum logic [3:0] {RESET_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef enum logic [3:0] {C_ALUR, C_ALUI, C_LDI, C_LD, C_ST, C_MULDIV, C_BR, C_HALT, C_NOP} cls_t;

  state_t      state_q, state_d;
  logic [31:0] ir_d;
  cls_t        cls;
  logic        gra, grb, grc, rin, rout, baout, last;
  logic [3:0]  field;

  // PC clear lives in the datapath; the reset vector is kept for reference only.
  logic [31:0] unused_pc_reset;
  assign unused_pc_reset = PC_RESET;

  function automatic cls_t classify(input logic [4:0] op);
    case (op) inside
      [5'd3:5'd10]:  classify = C_ALUR;
      [5'd11:5'd13]: classify = C_ALUI;
      5'd0:          classify = C_LD;
      5'd1:          classify = C_LDI;
      5'd2:          classify = C_ST;
      5'd14, 5'd15:  classify = C_MULDIV;
      5'd18:         classify = C_BR;
      5'd26:         classify = C_HALT;
      default:       classify = C_NOP;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= RESET_S;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    {PCout, PCin, incPC, MARin, MDRin, MDRout, Read, Write} = '0;
    {Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Cout, CONin}  = '0;
    alu_op = '0;
    run    = 1'b0;
    {gra, grb, grc, rin, rout, baout} = '0;
    last   = 1'b0;
    cls    = classify(ir_q[31:27]);
    case (state_q)
      RESET_S: state_d = T0;
      T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; incPC = 1'b1;
        state_d = T1;
      end
      T1: begin
        run = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = T2;
      end
      T2: begin
        // IR is still the old word here, so branch on the opcode being loaded.
        run = 1'b1; MDRout = 1'b1;
        ir_d = bus_in;
        case (classify(bus_in[31:27]))
          C_HALT:  state_d = HALT;
          C_NOP:   last = 1'b1;
          default: state_d = T3;
        endcase
      end
      T3: begin
        run = 1'b1;
        state_d = T4;
        case (cls)
          C_ALUR, C_ALUI:   begin grb = 1'b1; rout = 1'b1; Yin = 1'b1; end
          C_LDI, C_LD, C_ST: begin grb = 1'b1; baout = 1'b1; Yin = 1'b1; end
          C_MULDIV:         begin gra = 1'b1; rout = 1'b1; Yin = 1'b1; end
          C_BR:             begin gra = 1'b1; rout = 1'b1; CONin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        run = 1'b1;
        state_d = T5;
        case (cls)
          C_ALUR:            begin grc = 1'b1; rout = 1'b1; Zin = 1'b1; alu_op = ir_q[31:27]; end
          C_ALUI:            begin Cout = 1'b1; Zin = 1'b1; alu_op = ir_q[31:27]; end
          C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
          C_MULDIV:          begin grb = 1'b1; rout = 1'b1; Zin = 1'b1; alu_op = ir_q[31:27]; end
          C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        run = 1'b1;
        state_d = T6;
        case (cls)
          C_ALUR, C_ALUI, C_LDI: begin ZLowOut = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
          C_LD, C_ST:            begin ZLowOut = 1'b1; MARin = 1'b1; end
          C_MULDIV:              begin ZLowOut = 1'b1; LOin = 1'b1; end
          C_BR:                  begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
          default: ;
        endcase
      end
      T6: begin
        run = 1'b1;
        state_d = T7;
        case (cls)
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin gra = 1'b1; rout = 1'b1; MDRin = 1'b1; end
          C_MULDIV: begin ZHighOut = 1'b1; HIin = 1'b1; last = 1'b1; end
          C_BR: begin
            ZLowOut = con_ff; PCin = con_ff; last = 1'b1;
          end
          default: ;
        endcase
      end
      T7: begin
        run  = 1'b1;
        last = 1'b1;
        case (cls)
          C_LD:    begin MDRout = 1'b1; gra = 1'b1; rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      HALT:    state_d = HALT;
      default: state_d = RESET_S;
    endcase
    if (last) state_d = stop ? HALT : T0;
  end

  // BAout reads register 0 as a literal zero, so base-less addressing works.
  always_comb begin
    field = 4'd0;
    if (gra)      field = ir_q[26:23];
    else if (grb) field = ir_q[22:19];
    else if (grc) field = ir_q[18:15];
    Rin_vec  = rin ? (16'd1 << field) : 16'd0;
    Rout_vec = (rout || (baout && field != 4'd0)) ? (16'd1 << field) : 16'd0;
  end

  assign C_sext = {{13{ir_q[18]}}, ir_q[18:0]};

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven directed bench for control_sequencer: one row per clock, outputs checked mid-cycle.
module tb_control_sequencer;
  logic        clk, clr, con_ff, stop;
  logic [31:0] bus_in;
  logic [15:0] Rin_vec, Rout_vec;
  logic [31:0] C_sext, ir_q;
  logic [4:0]  alu_op;
  logic PCout, PCin, incPC, MARin, MDRin, MDRout, Read, Write;
  logic Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Cout, CONin, run;

  control_sequencer dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .con_ff(con_ff), .stop(stop),
    .Rin_vec(Rin_vec), .Rout_vec(Rout_vec), .C_sext(C_sext), .alu_op(alu_op),
    .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .Yin(Yin), .Zin(Zin),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
    .Cout(Cout), .CONin(CONin), .run(run), .ir_q(ir_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [15:0] S_PCOUT = 16'h8000, S_PCIN = 16'h4000, S_INC = 16'h2000, S_MARIN = 16'h1000;
  localparam logic [15:0] S_MDRIN = 16'h0800, S_MDROUT = 16'h0400, S_READ = 16'h0200, S_WRITE = 16'h0100;
  localparam logic [15:0] S_YIN = 16'h0080, S_ZIN = 16'h0040, S_ZLO = 16'h0020, S_ZHI = 16'h0010;
  localparam logic [15:0] S_HIIN = 16'h0008, S_LOIN = 16'h0004, S_COUT = 16'h0002, S_CONIN = 16'h0001;

  localparam logic [31:0] ADD_IR  = 32'h1A0B8000;  // add  R4,R1,R7
  localparam logic [31:0] LDI_IR  = 32'h0907FFFB;  // ldi  R2,-5(R0)
  localparam logic [31:0] ST_IR   = 32'h11980055;  // st   0x55(R3),R3
  localparam logic [31:0] LD_IR   = 32'h02B00010;  // ld   R5,0x10(R6)
  localparam logic [31:0] MUL_IR  = 32'h71480000;  // mul  R2,R9
  localparam logic [31:0] BR_IR   = 32'h91800020;  // br   R3,0x20
  localparam logic [31:0] ANDI_IR = 32'h6097FFFF;  // andi R1,R2,-1
  localparam logic [31:0] NOP_IR  = 32'hC8000000;
  localparam logic [31:0] SUB_IR  = 32'h27870000;  // sub  R15,R0,R14
  localparam logic [31:0] HALT_IR = 32'hD0000000;

  typedef struct {
    logic        clr;
    logic [31:0] bus;
    logic        con;
    logic        stp;
    logic [15:0] strb, rin, rout;
    logic [4:0]  alu;
    logic        run;
    logic [31:0] ir;
  } vec_t;

  vec_t        vq[$];
  int          total = 0, bad = 0;
  logic [31:0] cur_ir;
  logic        cur_con;
  logic [15:0] strb_act;

  assign strb_act = {PCout, PCin, incPC, MARin, MDRin, MDRout, Read, Write,
                     Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Cout, CONin};

  task automatic push(input logic c, input logic [31:0] b, input logic st, input logic [15:0] s,
                      input logic [15:0] ri, input logic [15:0] ro, input logic [4:0] a, input logic rn);
    vec_t v;
    v.clr = c; v.bus = b; v.con = cur_con; v.stp = st;
    v.strb = s; v.rin = ri; v.rout = ro; v.alu = a; v.run = rn; v.ir = cur_ir;
    vq.push_back(v);
  endtask

  task automatic ex(input logic [15:0] s, input logic [15:0] ri, input logic [15:0] ro, input logic [4:0] a);
    push(1'b0, 32'h0, 1'b0, s, ri, ro, a, 1'b1);
  endtask

  task automatic idle(input logic c);
    push(c, 32'hDEADBEEF, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] b, input logic st);
    ex(S_PCOUT | S_MARIN | S_INC, 16'h0, 16'h0, 5'd0);
    ex(S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0);
    push(1'b0, b, st, S_MDROUT, 16'h0, 16'h0, 5'd0, 1'b1);
    cur_ir = b;
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL row %0d %s: got %h want %h", idx, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    clr = v.clr; bus_in = v.bus; con_ff = v.con; stop = v.stp;
    #1;
    cmp("strobes",  idx, {16'h0, strb_act}, {16'h0, v.strb});
    cmp("Rin_vec",  idx, {16'h0, Rin_vec},  {16'h0, v.rin});
    cmp("Rout_vec", idx, {16'h0, Rout_vec}, {16'h0, v.rout});
    cmp("alu_op",   idx, {27'h0, alu_op},   {27'h0, v.alu});
    cmp("run",      idx, {31'h0, run},      {31'h0, v.run});
    cmp("ir_q",     idx, ir_q, v.ir);
    cmp("C_sext",   idx, C_sext, {{13{v.ir[18]}}, v.ir[18:0]});
  endtask

  task automatic run_queue(input int base);
    foreach (vq[i]) apply(vq[i], base + i);
    vq.delete();
  endtask

  initial begin
    clr = 1'b1; bus_in = 32'h0; con_ff = 1'b0; stop = 1'b0;
    cur_ir = 32'h0; cur_con = 1'b0;
    repeat (2) @(posedge clk);

    idle(1'b0);                                         // RESET_S after clr falls
    fetch(ADD_IR, 1'b0);
    ex(S_YIN, 16'h0, 16'h0002, 5'd0);
    ex(S_ZIN, 16'h0, 16'h0080, 5'd3);
    ex(S_ZLO, 16'h0010, 16'h0, 5'd0);
    fetch(LDI_IR, 1'b0);
    ex(S_YIN, 16'h0, 16'h0, 5'd0);                      // BAout of R0 drives nothing
    ex(S_COUT | S_ZIN, 16'h0, 16'h0, 5'd3);
    ex(S_ZLO, 16'h0004, 16'h0, 5'd0);
    fetch(ST_IR, 1'b0);
    ex(S_YIN, 16'h0, 16'h0008, 5'd0);
    ex(S_COUT | S_ZIN, 16'h0, 16'h0, 5'd3);
    ex(S_ZLO | S_MARIN, 16'h0, 16'h0, 5'd0);
    ex(S_MDRIN, 16'h0, 16'h0008, 5'd0);
    ex(S_WRITE, 16'h0, 16'h0, 5'd0);
    fetch(LD_IR, 1'b0);
    ex(S_YIN, 16'h0, 16'h0040, 5'd0);
    ex(S_COUT | S_ZIN, 16'h0, 16'h0, 5'd3);
    ex(S_ZLO | S_MARIN, 16'h0, 16'h0, 5'd0);
    ex(S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0);
    ex(S_MDROUT, 16'h0020, 16'h0, 5'd0);
    fetch(MUL_IR, 1'b0);
    ex(S_YIN, 16'h0, 16'h0004, 5'd0);
    ex(S_ZIN, 16'h0, 16'h0200, 5'd14);
    ex(S_ZLO | S_LOIN, 16'h0, 16'h0, 5'd0);
    ex(S_ZHI | S_HIIN, 16'h0, 16'h0, 5'd0);
    for (int k = 0; k < 2; k++) begin                   // branch not taken, then taken
      cur_con = (k == 1);
      fetch(BR_IR, 1'b0);
      ex(S_CONIN, 16'h0, 16'h0008, 5'd0);
      ex(S_PCOUT | S_YIN, 16'h0, 16'h0, 5'd0);
      ex(S_COUT | S_ZIN, 16'h0, 16'h0, 5'd3);
      ex(cur_con ? (S_ZLO | S_PCIN) : 16'h0, 16'h0, 16'h0, 5'd0);
    end
    cur_con = 1'b0;
    fetch(ANDI_IR, 1'b0);
    ex(S_YIN, 16'h0, 16'h0004, 5'd0);
    ex(S_COUT | S_ZIN, 16'h0, 16'h0, 5'd12);
    ex(S_ZLO, 16'h0002, 16'h0, 5'd0);
    fetch(NOP_IR, 1'b0);                                // nop returns straight to T0
    fetch(SUB_IR, 1'b0);
    ex(S_YIN, 16'h0, 16'h0001, 5'd0);                   // plain Rout of R0 does drive bit 0
    push(1'b0, 32'h0, 1'b1, S_ZIN, 16'h0, 16'h4000, 5'd4, 1'b1);
    push(1'b0, 32'h0, 1'b1, S_ZLO, 16'h8000, 16'h0, 5'd0, 1'b1);
    repeat (3) idle(1'b0);                              // HALT holds
    idle(1'b1);
    cur_ir = 32'h0;
    idle(1'b0);
    fetch(HALT_IR, 1'b0);
    repeat (2) idle(1'b0);
    idle(1'b1);
    cur_ir = 32'h0;
    idle(1'b0);
    run_queue(0);

    // clr held two cycles in the middle of a load
    fetch(LD_IR, 1'b0);
    ex(S_YIN, 16'h0, 16'h0040, 5'd0);
    ex(S_COUT | S_ZIN, 16'h0, 16'h0, 5'd3);
    ex(S_ZLO | S_MARIN, 16'h0, 16'h0, 5'd0);
    push(1'b1, 32'h0, 1'b0, S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    cur_ir = 32'h0;
    idle(1'b1);
    idle(1'b0);
    run_queue(1000);

    // stop raised at a nop's only boundary goes straight to HALT
    fetch(NOP_IR, 1'b1);
    repeat (2) idle(1'b0);
    run_queue(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
